// File: rtl/bus_pkg.sv
// Shared types and default widths for the bus controller slice.
// Holds the FSM state encoding and an index-width helper.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    ACCESS,
    RESP
  } bus_state_t;

  localparam int N_REQ_D   = 4;
  localparam int ADDR_W_D  = 16;
  localparam int DATA_W_D  = 16;
  localparam int DID_W_D   = 3;
  localparam int TIMEOUT_D = 15;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr.
// Ports: req, ptr in; one-hot grant and its index out.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int N_REQ = N_REQ_D,
  parameter int IDW   = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_ctrl.sv
// Round-robin bus controller: one transaction at a time through the
// address decoder; misses (and timeouts with BUS_CTRL_TIMEOUT_EN) answer
// with rsp_err. Ports: req_* from requesters, rsp_* back, bus_* to the
// decoder/devices, dec_hit/dec_did from decoder, dev_ack/dev_rdata back.
module bus_ctrl
  import bus_pkg::*;
#(
  parameter int N_REQ   = N_REQ_D,
  parameter int ADDR_W  = ADDR_W_D,
  parameter int DATA_W  = DATA_W_D,
  parameter int DID_W   = DID_W_D,
  parameter int TIMEOUT = TIMEOUT_D,
  localparam int IDW    = idx_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_wr,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    bus_rd,
  output logic                    bus_wr,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [DATA_W-1:0]       bus_wdata,
  output logic [DID_W-1:0]        bus_did,
  input  logic                    dec_hit,
  input  logic [DID_W-1:0]        dec_did,
  input  logic                    dev_ack,
  input  logic [DATA_W-1:0]       dev_rdata
);

  bus_state_t        state, nstate;
  logic [IDW-1:0]    ptr_q, id_q, gidx;
  logic [N_REQ-1:0]  gnt;
  logic              wr_q, err_q, tmo, any;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [DID_W-1:0]  did_q;

  assign any = |req_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (gnt),
    .idx   (gidx)
  );

`ifdef BUS_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;

  // Ack in the last allowed cycle still wins over the timeout.
  assign tmo = (state == ACCESS) && !dev_ack
            && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state == DECODE) begin
      cnt_q <= '0;
    end else if (state == ACCESS && !dev_ack) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:   if (any) nstate = DECODE;
      DECODE: nstate = dec_hit ? ACCESS : RESP;
      ACCESS: if (dev_ack || tmo) nstate = RESP;
      RESP:   nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      id_q    <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      did_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            id_q    <= gidx;
            wr_q    <= req_wr[gidx];
            addr_q  <= req_addr[int'(gidx)*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[int'(gidx)*DATA_W +: DATA_W];
            did_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        DECODE: begin
          if (dec_hit) did_q <= dec_did;
          else         err_q <= 1'b1;
        end
        ACCESS: begin
          if (dev_ack) begin
            if (!wr_q) rdata_q <= dev_rdata;
          end else if (tmo) begin
            err_q <= 1'b1;
          end
        end
        RESP: begin
          ptr_q <= (id_q == IDW'(N_REQ - 1))
                 ? '0 : id_q + 1'b1;
        end
      endcase
    end
  end

  // rst gate keeps req_ready quiet while reset is held.
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;

  assign bus_rd    = (state == DECODE || state == ACCESS) && !wr_q;
  assign bus_wr    = (state == DECODE || state == ACCESS) && wr_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_did   = did_q;

  assign rsp_valid = (state == RESP);
  assign rsp_id    = rsp_valid ? id_q    : '0;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid ? err_q   : 1'b0;

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl: read, write, miss, timeout/hang,
// async reset mid-access and round-robin fairness.
module tb_bus_ctrl;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DD = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_wr, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rsp_rdata, bus_wdata, dev_rdata;
  logic          bus_rd, bus_wr, dec_hit, dev_ack;
  logic [AW-1:0] bus_addr;
  logic [DD-1:0] bus_did, dec_did;

  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] wd_a   [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = addr_a[i];
      req_wdata[i*DW +: DW] = wd_a[i];
    end
  end

  bus_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_did   (bus_did),
    .dec_hit   (dec_hit),
    .dec_did   (dec_did),
    .dev_ack   (dev_ack),
    .dev_rdata (dev_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise one request, check its grant, return sampled in DECODE.
  task automatic issue(input int i, input logic wr,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_wr[i]    = wr;
    addr_a[i]    = a;
    wd_a[i]      = d;
    #1;
    chk("grant", 32'(req_ready), 32'(1 << i));
    tick();
    req_valid[i] = 1'b0;
  endtask

  int lat, seen;
  int order[$];
  int exp_o[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_wr    = '0;
    dec_hit   = 1'b0;
    dec_did   = '0;
    dev_ack   = 1'b0;
    dev_rdata = '0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = '0;
      wd_a[i]   = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_bus_rd", 32'(bus_rd), 0);
    chk("rst_bus_wr", 32'(bus_wr), 0);
    chk("rst_bus_addr", 32'(bus_addr), 0);
    chk("rst_bus_did", 32'(bus_did), 0);
    chk("rst_ready", 32'(req_ready), 0);
    rst = 1'b0;
    tick();

    // read hit, ack on first ACCESS cycle
    dec_hit = 1'b1;
    dec_did = 3'd2;
    issue(0, 1'b0, 16'h1000, 16'h0);
    chk("rd_bus_rd", 32'(bus_rd), 1);
    chk("rd_bus_wr", 32'(bus_wr), 0);
    chk("rd_bus_addr", 32'(bus_addr), 32'h1000);
    tick();
    chk("rd_bus_did", 32'(bus_did), 2);
    chk("rd_early_rsp", 32'(rsp_valid), 0);
    dev_ack   = 1'b1;
    dev_rdata = 16'hBEEF;
    tick();
    dev_ack = 1'b0;
    chk("rd_rsp_valid", 32'(rsp_valid), 1);
    chk("rd_rsp_id", 32'(rsp_id), 0);
    chk("rd_rsp_rdata", 32'(rsp_rdata), 32'hBEEF);
    chk("rd_rsp_err", 32'(rsp_err), 0);
    chk("rd_resp_bus_rd", 32'(bus_rd), 0);
    tick();
    chk("rd_rsp_drop", 32'(rsp_valid), 0);
    chk("rd_rdata_zero", 32'(rsp_rdata), 0);

    // write, ack on fourth ACCESS cycle
    dev_rdata = 16'h5555;
    dec_did   = 3'd1;
    issue(1, 1'b1, 16'h2004, 16'h1234);
    chk("wr_bus_wr", 32'(bus_wr), 1);
    chk("wr_bus_wdata", 32'(bus_wdata), 32'h1234);
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk("wr_hold_wdata", 32'(bus_wdata), 32'h1234);
      chk("wr_hold_addr", 32'(bus_addr), 32'h2004);
      chk("wr_hold_wr", 32'(bus_wr), 1);
      chk("wr_no_rsp", 32'(rsp_valid), 0);
      if (k == 4) dev_ack = 1'b1;
      tick();
    end
    dev_ack = 1'b0;
    chk("wr_rsp_valid", 32'(rsp_valid), 1);
    chk("wr_rsp_id", 32'(rsp_id), 1);
    chk("wr_rsp_rdata", 32'(rsp_rdata), 0);
    chk("wr_rsp_err", 32'(rsp_err), 0);
    tick();

    // decoder miss: RESP two cycles after grant
    dec_hit = 1'b0;
    issue(2, 1'b1, 16'hFFFF, 16'hAAAA);
    chk("miss_bus_wr", 32'(bus_wr), 1);
    dev_ack = 1'b1;
    tick();
    dev_ack = 1'b0;
    chk("miss_rsp_valid", 32'(rsp_valid), 1);
    chk("miss_rsp_id", 32'(rsp_id), 2);
    chk("miss_rsp_err", 32'(rsp_err), 1);
    chk("miss_rsp_rdata", 32'(rsp_rdata), 0);
    chk("miss_bus_wr_off", 32'(bus_wr), 0);
    tick();
    chk("miss_idle", 32'(rsp_valid), 0);

    // no ack in ACCESS
    dec_hit = 1'b1;
    dec_did = 3'd5;
    issue(3, 1'b0, 16'h3000, 16'h0);
    tick();
    lat = 2;
`ifdef BUS_CTRL_TIMEOUT_EN
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("tmo_latency", 32'(lat), 17);
    chk("tmo_rsp_err", 32'(rsp_err), 1);
    chk("tmo_rsp_rdata", 32'(rsp_rdata), 0);
    chk("tmo_rsp_id", 32'(rsp_id), 3);
    tick();
    dev_rdata = 16'hA5A5;
    issue(0, 1'b0, 16'h0040, 16'h0);
    tick();
    repeat (14) tick();
    chk("ack15_no_rsp", 32'(rsp_valid), 0);
    dev_ack = 1'b1;
    tick();
    dev_ack = 1'b0;
    chk("ack15_rsp_valid", 32'(rsp_valid), 1);
    chk("ack15_rsp_err", 32'(rsp_err), 0);
    chk("ack15_rsp_rdata", 32'(rsp_rdata), 32'hA5A5);
    tick();
    issue(1, 1'b0, 16'h0080, 16'h0);
    tick();
    tick();
`else
    seen = 0;
    repeat (40) begin
      if (rsp_valid) seen++;
      tick();
    end
    chk("hang_no_rsp", 32'(seen), 0);
    chk("hang_bus_rd", 32'(bus_rd), 1);
`endif

    // async reset in the middle of ACCESS
    #3;
    rst = 1'b1;
    #1;
    chk("arst_bus_rd", 32'(bus_rd), 0);
    chk("arst_bus_addr", 32'(bus_addr), 0);
    chk("arst_bus_did", 32'(bus_did), 0);
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // fairness with every requester pending
    dev_ack   = 1'b1;
    dev_rdata = 16'h0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = AW'(16'h4000 + i);
      req_wr[i] = 1'b0;
    end
    req_valid = '1;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      #1;
      chk("onehot_ready", 32'($onehot0(req_ready)), 1);
      for (int i = 0; i < N; i++)
        if (req_ready[i]) order.push_back(i);
      @(posedge clk);
    end
    req_valid = '0;
    dev_ack   = 1'b0;
    chk("fair_count", 32'(order.size()), 5);
    for (int i = 0; i < 5; i++)
      chk("fair_order",
          (order.size() > i) ? 32'(order[i]) : 32'd99,
          32'(exp_o[i]));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
